// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART blocks.
//   uart_rx_state_t : receiver FSM states
//   UART_DATA_BITS  : payload bits per frame (8N1)
//   clks_per_bit()  : integer-truncated clocks per bit for a clock/baud pair
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_rx_state_t;

    function automatic int clks_per_bit(input int freq, input int baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: generic two-flop synchroniser for asynchronous inputs.
// Ports:
//   clk   - destination clock
//   reset - synchronous active-high reset, loads RST_VAL into both stages
//   d     - asynchronous input
//   q     - synchronised output (two clk cycles of latency)
module sync_2ff #(
    parameter int   WIDTH   = 1,
    parameter logic RST_VAL = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= {WIDTH{RST_VAL}};
            q    <= {WIDTH{RST_VAL}};
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver for the cpu's io_rx pin.
// Each correctly framed byte is presented on rx_data with a one-cycle
// rx_valid strobe; a low stop bit gives a one-cycle rx_frame_err strobe.
// Ports:
//   clk          - core clock, rising edge
//   reset        - synchronous active-high reset
//   io_rx        - asynchronous serial line, idles high
//   rx_data      - last correctly framed byte
//   rx_valid     - strobe: rx_data has just been updated
//   rx_frame_err - strobe: stop bit sampled low
//   rx_busy      - high while a frame is in progress
// Build option: define UART_RX_MAJORITY_EN to decide every sample point by a
// 2-of-3 vote over the last three rx_s values instead of a single sample.
// CLKS_PER_BIT must be at least 8.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ  = 40_000_000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      io_rx,
    output logic [UART_DATA_BITS-1:0] rx_data,
    output logic                      rx_valid,
    output logic                      rx_frame_err,
    output logic                      rx_busy
);

    localparam int HALF = (CLKS_PER_BIT - 1) / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int IW   = $clog2(UART_DATA_BITS);

    localparam logic [CW-1:0] BIT_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] START_LAST = CW'(HALF - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(UART_DATA_BITS - 1);

    logic                      rx_s;
    logic                      smp;
    uart_rx_state_t            state;
    logic [CW-1:0]             cnt;
    logic [IW-1:0]             bit_idx;
    logic [UART_DATA_BITS-1:0] shreg;
    logic                      armed;

    sync_2ff #(.WIDTH(1), .RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (io_rx),
        .q     (rx_s)
    );

`ifdef UART_RX_MAJORITY_EN
    // hist holds rx_s from the two previous cycles, so at cnt==target the
    // vote covers cnt = target-2, target-1 and target.
    logic [1:0] hist;

    always_ff @(posedge clk) begin
        if (reset) hist <= 2'b11;
        else       hist <= {hist[0], rx_s};
    end

    assign smp = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
    assign smp = rx_s;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            shreg        <= '0;
            armed        <= 1'b0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_busy      <= 1'b0;
        end else begin
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    // armed requires a high line first, so a break or stuck-low
                    // line after a frame error cannot start a new frame.
                    if (!rx_s && armed) begin
                        state   <= START;
                        armed   <= 1'b0;
                        rx_busy <= 1'b1;
                    end else if (rx_s) begin
                        armed <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == START_LAST) begin
                        cnt <= '0;
                        if (!smp) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            // line went back high: glitch, not a start bit
                            state   <= IDLE;
                            rx_busy <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        shreg   <= {smp, shreg[UART_DATA_BITS-1:1]};
                        bit_idx <= bit_idx + IW'(1);
                        if (bit_idx == IDX_LAST) state <= STOP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        state   <= IDLE;
                        armed   <= 1'b0;
                        rx_busy <= 1'b0;
                        if (smp) begin
                            rx_data  <= shreg;
                            rx_valid <= 1'b1;
                        end else begin
                            rx_frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx at 40 MHz / 115200 baud.
// A line driver builds frames bit by bit; the expected byte stream, the
// frame start times and the last good byte are kept as a simple reference
// model, and the strobes seen on the outputs are collected for comparison.
module tb_uart_rx;
    timeunit 1ns;
    timeprecision 1ps;

    localparam int CPB   = 347;
    localparam int HALF  = (CPB - 1) / 2;
    localparam int LAT   = HALF + 9 * CPB + 3;
    localparam int FRAME = 10 * CPB;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       io_rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int err_cnt  = 0;
    int both_cnt = 0;

    logic [7:0] got_q[$];
    int         got_cyc[$];
    logic [7:0] exp_q[$];
    int         start_cyc[$];
    logic [7:0] last_good = 8'h00;
    int         exp_err   = 0;

    uart_rx #(.CLK_FREQ_HZ(40_000_000), .BAUD(115200)) dut (
        .clk          (clk),
        .reset        (reset),
        .io_rx        (io_rx),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
        .rx_busy      (rx_busy)
    );

    always #12.5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // collect strobes away from the active edge
    always @(negedge clk) begin
        if (rx_valid) begin
            got_q.push_back(rx_data);
            got_cyc.push_back(cyc);
        end
        if (rx_frame_err) err_cnt++;
        if (rx_valid && rx_frame_err) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic check_near(input string tag, input int obs, input int exp, input int tol);
        total++;
        assert (obs >= exp - tol && obs <= exp + tol) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d+-%0d", tag, obs, exp, tol);
        end
    endtask

    // Drive one frame starting at a negedge. The stop level is held for
    // CPB+hold cycles, then the line idles high for gap cycles. With glitch
    // set, each data bit is inverted for one clock at its centre.
    task automatic send(input logic [7:0] b, input logic stop, input int hold,
                        input int gap, input bit glitch);
        logic [7:0] e;
        e = b;
`ifndef UART_RX_MAJORITY_EN
        if (glitch) e = ~b;  // single-sample receiver takes every glitch
`endif
        if (stop) begin
            exp_q.push_back(e);
            start_cyc.push_back(cyc + 1);
            last_good = e;
        end else begin
            exp_err++;
        end
        io_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            io_rx = b[i];
            if (glitch) begin
                repeat (HALF) @(negedge clk);
                io_rx = ~b[i];
                @(negedge clk);
                io_rx = b[i];
                repeat (CPB - HALF - 1) @(negedge clk);
            end else begin
                repeat (CPB) @(negedge clk);
            end
        end
        io_rx = stop;
        repeat (CPB + hold) @(negedge clk);
        io_rx = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    // Compare collected bytes against the model, then clear both sides.
    task automatic drain(input string tag);
        check({tag, "-count"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            check({tag, "-data"}, got_q.pop_front(), exp_q.pop_front());
            check_near({tag, "-latency"}, got_cyc.pop_front() - start_cyc.pop_front(), LAT, 1);
        end
        got_q.delete();
        got_cyc.delete();
        exp_q.delete();
        start_cyc.delete();
    endtask

    initial begin
        logic [7:0] b;
        logic       good;
        int         g01, g12;

        repeat (3) @(negedge clk);
        check("rst-data",  rx_data, 8'h00);
        check("rst-valid", rx_valid, 1'b0);
        check("rst-err",   rx_frame_err, 1'b0);
        check("rst-busy",  rx_busy, 1'b0);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        // single byte
        send(8'hA5, 1'b1, 0, 20, 1'b0);
        drain("a5");
        check("a5-err", err_cnt, exp_err);
        check("a5-busy", rx_busy, 1'b0);
        check("a5-rxdata", rx_data, 8'hA5);

        // back-to-back frames, one stop bit, no gap
        send(8'h00, 1'b1, 0, 0, 1'b0);
        send(8'hFF, 1'b1, 0, 0, 1'b0);
        send(8'h13, 1'b1, 0, 20, 1'b0);
        g01 = 0;
        g12 = 0;
        if (got_cyc.size() == 3) begin
            g01 = got_cyc[1] - got_cyc[0];
            g12 = got_cyc[2] - got_cyc[1];
        end
        check_near("b2b-gap01", g01, FRAME, 1);
        check_near("b2b-gap12", g12, FRAME, 1);
        drain("b2b");

        // false start: 100-clock low pulse
        io_rx = 1'b0;
        repeat (100) @(negedge clk);
        io_rx = 1'b1;
        repeat (600) @(negedge clk);
        check("fs-valid", got_q.size(), 0);
        check("fs-err", err_cnt, exp_err);
        check("fs-busy", rx_busy, 1'b0);

        // frame error, then line held low, then a good frame
        send(8'h5A, 1'b0, 2000, 20, 1'b0);
        check("fe-err", err_cnt, exp_err);
        check("fe-nodata", got_q.size(), 0);
        check("fe-rxdata", rx_data, 8'h13);
        send(8'h3C, 1'b1, 0, 20, 1'b0);
        drain("fe-3c");
        check("fe-err2", err_cnt, exp_err);

        // reset during bit 4 of 8'hC3
        b = 8'hC3;
        io_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            io_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        io_rx = b[4];
        repeat (100) @(negedge clk);
        reset = 1'b1;
        io_rx = 1'b1;
        repeat (3) @(negedge clk);
        check("mr-data",  rx_data, 8'h00);
        check("mr-valid", rx_valid, 1'b0);
        check("mr-err",   rx_frame_err, 1'b0);
        check("mr-busy",  rx_busy, 1'b0);
        reset = 1'b0;
        last_good = 8'h00;
        repeat (2 * CPB) @(negedge clk);
        check("mr-nostrobe", got_q.size(), 0);
        check("mr-noerr", err_cnt, exp_err);
        send(8'h7E, 1'b1, 0, 20, 1'b0);
        drain("mr-7e");

        // one-clock glitch at every data-bit centre
        send(8'h96, 1'b1, 0, 20, 1'b1);
        drain("glitch");
        check("glitch-rxdata", rx_data, last_good);

        // randomized frames, gaps and stop bits
        for (int k = 0; k < 6; k++) begin
            b    = 8'($urandom);
            good = ($urandom_range(0, 3) != 0);
            if (good) send(b, 1'b1, 0, $urandom_range(0, 300), 1'b0);
            else      send(b, 1'b0, $urandom_range(0, 50), $urandom_range(5, 300), 1'b0);
        end
        repeat (20) @(negedge clk);
        drain("rand");
        check("rand-err", err_cnt, exp_err);
        check("rand-rxdata", rx_data, last_good);
        check("rand-busy", rx_busy, 1'b0);

        check("no-overlap", both_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
